// File: rtl/pipeline_ctrl.sv
// Hazard and stall sequencer for the 5-stage RV32I pipeline.
// Produces per-stage buffer load enables and bubble (flush) controls, and
// keeps saturating performance counters for stall and redirect activity.
module pipeline_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             imem_read,
  input  logic             imem_resp,
  input  logic             dmem_read,
  input  logic             dmem_write,
  input  logic             dmem_resp,
  input  logic             ex_valid,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rd,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [1:0]       pcmux_sel,
  output logic             load_pc,
  output logic             load_if_id,
  output logic             load_id_ex,
  output logic             load_ex_mem,
  output logic             load_mem_wb,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic {S_RUN, S_WAIT} state_t;

  state_t           r_state;
  logic             r_imem_done;
  logic             r_dmem_done;
  logic [CNT_W-1:0] r_stall_cycles;
  logic [CNT_W-1:0] r_flush_count;

  state_t           w_state_next;
  logic             w_imem_done_next;
  logic             w_dmem_done_next;

  logic             w_dmem_req;
  logic             w_i_ok;
  logic             w_d_ok;
  logic             w_mem_stall;
  logic             w_redirect;
  logic             w_rs_match;
  logic             w_load_use;

  // Hazard detection: memory stall dominates, then redirect, then load-use.
  always_comb begin
    w_dmem_req  = dmem_read | dmem_write;
    w_i_ok      = ~imem_read | imem_resp | r_imem_done;
    w_d_ok      = ~w_dmem_req | dmem_resp | r_dmem_done;
    w_mem_stall = ~(w_i_ok & w_d_ok);
    w_redirect  = ex_valid & (pcmux_sel != 2'b00) & ~w_mem_stall;
    w_rs_match  = (id_uses_rs1 & (id_rs1 == ex_rd)) |
                  (id_uses_rs2 & (id_rs2 == ex_rd));
    w_load_use  = ex_valid & ex_mem_read & (ex_rd != 5'd0) & w_rs_match &
                  ~w_redirect & ~w_mem_stall;
  end

  // Next-state logic: stickies remember a response that arrived while the
  // other memory port was still outstanding, so it is not lost.
  always_comb begin
    w_state_next     = r_state;
    w_imem_done_next = 1'b0;
    w_dmem_done_next = 1'b0;
    case (r_state)
      S_RUN: begin
        if (w_mem_stall) begin
          w_state_next     = S_WAIT;
          w_imem_done_next = imem_resp & imem_read;
          w_dmem_done_next = dmem_resp & w_dmem_req;
        end
      end
      S_WAIT: begin
        if (w_mem_stall) begin
          w_imem_done_next = r_imem_done | (imem_resp & imem_read);
          w_dmem_done_next = r_dmem_done | (dmem_resp & w_dmem_req);
        end else begin
          w_state_next = S_RUN;
        end
      end
      default: w_state_next = S_RUN;
    endcase
  end

  // State and sticky flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_RUN;
      r_imem_done <= 1'b0;
      r_dmem_done <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_imem_done <= w_imem_done_next;
      r_dmem_done <= w_dmem_done_next;
    end
  end

  // Stage enables and bubble controls; everything is held off while in reset.
  always_comb begin
    load_pc     = 1'b1;
    load_if_id  = 1'b1;
    load_id_ex  = 1'b1;
    load_ex_mem = 1'b1;
    load_mem_wb = 1'b1;
    flush_if_id = 1'b0;
    flush_id_ex = 1'b0;
    if (rst || w_mem_stall) begin
      load_pc     = 1'b0;
      load_if_id  = 1'b0;
      load_id_ex  = 1'b0;
      load_ex_mem = 1'b0;
      load_mem_wb = 1'b0;
    end else if (w_redirect) begin
      // ID holds a wrong-path instruction, so it is squashed along with IF.
      flush_if_id = 1'b1;
      flush_id_ex = 1'b1;
    end else if (w_load_use) begin
      // Freeze PC and IF/ID for one cycle and push a bubble into ID/EX.
      load_pc     = 1'b0;
      load_if_id  = 1'b0;
      flush_id_ex = 1'b1;
    end
  end

  // Saturating performance counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cycles <= '0;
      r_flush_count  <= '0;
    end else begin
      if ((w_mem_stall | w_load_use) && (r_stall_cycles != {CNT_W{1'b1}}))
        r_stall_cycles <= r_stall_cycles + 1'b1;
      if (w_redirect && (r_flush_count != {CNT_W{1'b1}}))
        r_flush_count <= r_flush_count + 1'b1;
    end
  end

  assign stall_cycles = r_stall_cycles;
  assign flush_count  = r_flush_count;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: drives inputs just after the rising edge,
// checks combinational controls at the falling edge and counters after edges.
module tb_pipeline_ctrl;

  localparam int CNT_W = 4;

  // Control vector order: {load_pc, load_if_id, load_id_ex, load_ex_mem,
  //                        load_mem_wb, flush_if_id, flush_id_ex}
  localparam logic [6:0] C_NONE   = 7'b0000000;
  localparam logic [6:0] C_ALL    = 7'b1111100;
  localparam logic [6:0] C_BUBBLE = 7'b0011101;
  localparam logic [6:0] C_REDIR  = 7'b1111111;

  logic             clk;
  logic             rst;
  logic             imem_read, imem_resp;
  logic             dmem_read, dmem_write, dmem_resp;
  logic             ex_valid, ex_mem_read;
  logic [4:0]       ex_rd, id_rs1, id_rs2;
  logic             id_uses_rs1, id_uses_rs2;
  logic [1:0]       pcmux_sel;
  logic             load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb;
  logic             flush_if_id, flush_id_ex;
  logic [CNT_W-1:0] stall_cycles, flush_count;
  logic [6:0]       ctl;

  int n_checks = 0;
  int n_pass   = 0;

  pipeline_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .imem_read(imem_read), .imem_resp(imem_resp),
    .dmem_read(dmem_read), .dmem_write(dmem_write), .dmem_resp(dmem_resp),
    .ex_valid(ex_valid), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .pcmux_sel(pcmux_sel),
    .load_pc(load_pc), .load_if_id(load_if_id), .load_id_ex(load_id_ex),
    .load_ex_mem(load_ex_mem), .load_mem_wb(load_mem_wb),
    .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
    .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign ctl = {load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb,
                flush_if_id, flush_id_ex};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
      $display("check %-14s obs=%0h exp=%0h ok", tag, obs, exp);
    end else begin
      $display("FAIL %-14s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    imem_read = 0; imem_resp = 0;
    dmem_read = 0; dmem_write = 0; dmem_resp = 0;
    ex_valid = 0; ex_mem_read = 0; ex_rd = 0;
    id_rs1 = 0; id_rs2 = 0; id_uses_rs1 = 0; id_uses_rs2 = 0;
    pcmux_sel = 0;
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Check the combinational controls for the current input vector at negedge.
  task automatic check_ctl(input string tag, input logic [6:0] exp);
    @(negedge clk);
    check(tag, {25'd0, ctl}, {25'd0, exp});
  endtask

  task automatic do_reset();
    idle();
    rst = 1;
    tick();
    rst = 0;
  endtask

  initial begin
    // Reset with a fetch request and response pending: everything held off.
    idle();
    rst = 1; imem_read = 1; imem_resp = 1;
    check_ctl("rst_ctl", C_NONE);
    check("rst_stall", {28'd0, stall_cycles}, 32'd0);
    check("rst_flush", {28'd0, flush_count}, 32'd0);
    tick();
    rst = 0; idle();
    check_ctl("post_rst_ctl", C_ALL);
    check("post_rst_stall", {28'd0, stall_cycles}, 32'd0);

    // Fetch held three cycles, response on the third.
    do_reset();
    imem_read = 1;
    check_ctl("if_wait1", C_NONE);
    tick();
    check_ctl("if_wait2", C_NONE);
    tick();
    imem_resp = 1;
    check_ctl("if_resp", C_ALL);
    tick();
    idle();
    check("if_stall_cnt", {28'd0, stall_cycles}, 32'd2);
    check_ctl("if_after", C_ALL);

    // Fetch and load outstanding; fetch answers first, sticky must hold it.
    do_reset();
    imem_read = 1; dmem_read = 1;
    check_ctl("dual_c0", C_NONE);
    tick();
    imem_resp = 1;
    check_ctl("dual_c1", C_NONE);
    tick();
    imem_resp = 0;
    check_ctl("dual_c2", C_NONE);
    tick();
    check_ctl("dual_c3", C_NONE);
    tick();
    dmem_resp = 1;
    check_ctl("dual_c4", C_ALL);
    tick();
    dmem_resp = 0;
    check("dual_stall_cnt", {28'd0, stall_cycles}, 32'd4);
    // Both requests still high with no response: stickies must have cleared.
    check_ctl("dual_sticky_clr", C_NONE);
    tick();
    idle();

    // Load-use hazard on rs2: one bubble, then release once EX is a bubble.
    do_reset();
    ex_valid = 1; ex_mem_read = 1; ex_rd = 5; id_rs2 = 5; id_uses_rs2 = 1;
    check_ctl("lu_bubble", C_BUBBLE);
    tick();
    ex_valid = 0;
    check_ctl("lu_release", C_ALL);
    tick();
    check("lu_stall_cnt", {28'd0, stall_cycles}, 32'd1);

    // Redirect together with a load-use condition: redirect wins.
    do_reset();
    ex_valid = 1; ex_mem_read = 1; ex_rd = 5; id_rs1 = 5; id_uses_rs1 = 1;
    pcmux_sel = 2'd1;
    check_ctl("redir_prio", C_REDIR);
    tick();
    check("redir_flush_cnt", {28'd0, flush_count}, 32'd1);
    check("redir_stall_cnt", {28'd0, stall_cycles}, 32'd0);
    // x0 destination never creates a hazard.
    pcmux_sel = 0; ex_rd = 0; id_rs1 = 0;
    check_ctl("lu_x0", C_ALL);
    tick();
    check("lu_x0_stall", {28'd0, stall_cycles}, 32'd0);

    // Redirect while a load stalls two cycles: applied on the release cycle.
    do_reset();
    ex_valid = 1; pcmux_sel = 2'd2; dmem_read = 1;
    check_ctl("rd_stall1", C_NONE);
    tick();
    check_ctl("rd_stall2", C_NONE);
    check("rd_no_flush", {28'd0, flush_count}, 32'd0);
    tick();
    dmem_resp = 1;
    check_ctl("rd_release", C_REDIR);
    tick();
    idle();
    check("rd_flush_cnt", {28'd0, flush_count}, 32'd1);
    check("rd_stall_cnt", {28'd0, stall_cycles}, 32'd2);

    // Saturation of both counters at all-ones.
    do_reset();
    imem_read = 1;
    for (int i = 0; i < 15; i++) tick();
    check("sat_stall_max", {28'd0, stall_cycles}, 32'd15);
    tick();
    check("sat_stall_hold", {28'd0, stall_cycles}, 32'd15);
    do_reset();
    ex_valid = 1; pcmux_sel = 2'd3;
    for (int i = 0; i < 15; i++) tick();
    check("sat_flush_max", {28'd0, flush_count}, 32'd15);
    tick();
    check("sat_flush_hold", {28'd0, flush_count}, 32'd15);

    // Reset in the middle of a wait; a late response must not be remembered.
    do_reset();
    imem_read = 1;
    tick();
    tick();
    rst = 1;
    check_ctl("mid_rst_ctl", C_NONE);
    tick();
    rst = 0; imem_read = 0; imem_resp = 1;
    check_ctl("late_resp", C_ALL);
    check("mid_rst_stall", {28'd0, stall_cycles}, 32'd0);
    tick();
    imem_resp = 0; imem_read = 1;
    check_ctl("late_ignored", C_NONE);
    tick();
    idle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Hard bound so the run always ends on its own.
  initial begin
    #100000;
    $display("FAIL timeout obs=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
